// File: rtl/pingpong_pkg.sv
// pingpong_pkg: state type, default data width and log2 helper shared by the pingpong buffer and its arbiters.
package pingpong_pkg;

    typedef enum logic {IDLE, LOCK} state_e;

    localparam int DATA_WD_DEF = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/pingpong_wr_arb_rr_pick.sv
// rr_pick: combinational circular first-one finder; returns the first set bit of req at or after ptr.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walking from the farthest offset down leaves the nearest hit as the final assignment.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[W'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pingpong_wr_arb.sv
// pingpong_wr_arb: round-robin burst arbiter sharing one pingpong buffer write port among REQ_NUM producers.
module pingpong_wr_arb
    import pingpong_pkg::*;
#(
    parameter int REQ_NUM   = 4,
    parameter int DATA_WD   = DATA_WD_DEF,
    parameter int MAX_BURST = 4,
    parameter int ID_WD     = (clog2(REQ_NUM) < 1) ? 1 : clog2(REQ_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_NUM-1:0]         req_valid,
    input  logic [REQ_NUM*DATA_WD-1:0] req_data,
    input  logic [REQ_NUM-1:0]         req_last,
    output logic [REQ_NUM-1:0]         req_ready,
    output logic                       buf_valid,
    output logic [DATA_WD-1:0]         buf_data,
    output logic [ID_WD-1:0]           buf_id,
    output logic                       buf_last,
    input  logic                       buf_ready,
    output logic                       busy
);

    localparam int CNT_WD = clog2(MAX_BURST + 1);
    localparam logic [ID_WD-1:0] LAST_ID = ID_WD'(REQ_NUM - 1);

    state_e state_q, state_d;
    logic [ID_WD-1:0] owner_q, owner_d, ptr_q, ptr_d, cand, sel, next_id;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic [DATA_WD-1:0] data_arr [REQ_NUM];
    logic found, vld, fire, last_beat;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_data
        assign data_arr[g] = req_data[g*DATA_WD +: DATA_WD];
    end

    rr_pick #(.N(REQ_NUM), .W(ID_WD)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (found),
        .idx   (cand)
    );

    // IDLE exposes the round-robin candidate, LOCK pins the owner until its burst ends.
    always_comb begin
        sel = (state_q == LOCK) ? owner_q : cand;
        vld = !rst && ((state_q == LOCK) ? req_valid[sel] : found);
        fire = vld && buf_ready;
        last_beat = req_last[sel] || ((state_q == LOCK) ? (int'(cnt_q) + 1 == MAX_BURST) : (MAX_BURST == 1));
        next_id = (sel == LAST_ID) ? '0 : sel + 1'b1;
        buf_valid = vld;
        buf_data = rst ? '0 : data_arr[sel];
        buf_id = rst ? '0 : sel;
        buf_last = !rst && req_last[sel];
        req_ready = '0;
        req_ready[sel] = fire;
        busy = !rst && (state_q == LOCK);
        state_d = (fire && last_beat) ? IDLE : ((state_q == LOCK || found) ? LOCK : IDLE);
        owner_d = (state_q == IDLE && found) ? cand : owner_q;
        ptr_d = (fire && last_beat) ? next_id : ptr_q;
        cnt_d = (fire && last_beat) ? '0 : ((state_q == LOCK) ? cnt_q : '0) + CNT_WD'(fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
